// File: rtl/pc_fetch.sv
// Instruction fetch front end: holds the PC, issues one instruction-memory request
// at a time and presents the fetched word to decode with valid/ready handshaking.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        PCWr,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        flush_pending;

  logic [31:0] tgt_word;
  logic [31:0] pc_next_seq;
  logic [31:0] refetch_addr;
  logic        unused_tgt_lsbs;

  assign tgt_word        = {target[31:2], 2'b00};
  assign pc_next_seq     = pc + 32'd4;
  assign refetch_addr    = PCWr ? tgt_word : pc;
  assign unused_tgt_lsbs = ^target[1:0];

  assign imem_addr = req_addr;

  // imem_req/inst_valid are registered alongside state so each equals a state decode.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= {RESET_PC[31:2], 2'b00};
      req_addr      <= {RESET_PC[31:2], 2'b00};
      flush_pending <= 1'b0;
      inst          <= '0;
      inst_pc       <= '0;
      imem_req      <= 1'b0;
      inst_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PCWr) begin
            pc       <= tgt_word;
            req_addr <= tgt_word;
          end else begin
            req_addr <= pc;
          end
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem_ack) begin
            if (flush_pending || PCWr) begin
              // Stale response: drop it and start the corrected request next cycle.
              flush_pending <= 1'b0;
              pc            <= refetch_addr;
              req_addr      <= refetch_addr;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= req_addr;
              state      <= VALID;
              imem_req   <= 1'b0;
              inst_valid <= 1'b1;
            end
          end else if (PCWr) begin
            // Address must stay stable until the outstanding ack arrives.
            pc            <= tgt_word;
            flush_pending <= 1'b1;
          end
        end

        VALID: begin
          if (PCWr) begin
            pc         <= tgt_word;
            req_addr   <= tgt_word;
            state      <= FETCH;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end else if (inst_ready) begin
            pc         <= pc_next_seq;
            req_addr   <= pc_next_seq;
            state      <= FETCH;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: a latency-randomized instruction memory plus a
// transaction-level model of which address decode must see next.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        rst;
  logic        PCWr;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .PCWr       (PCWr),
    .target     (target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0200;
      2:       return 32'h0000_0042;
      3:       return 32'hFFFF_FFFC;
      default: return $urandom();
    endcase
  endfunction

  // Reference model: next address decode must receive, plus the held instruction.
  logic [31:0] exp_addr, exp_inst, exp_pc, mem_addr;
  bit          exp_valid, exp_idle, mem_busy, redirected, wrap_pending, saw_wrap;
  int          mem_cnt;
  int          pcwr_pct, ready_pct, lat_max;

  task automatic tick(input bit do_rst, input bit force_pcwr, input logic [31:0] force_tgt);
    bit          started, ack_now, pw, rdy, deliver, accept, nv;
    logic [31:0] tgt;
    started = 1'b0;
    check("imem_req",   {31'b0, imem_req},   {31'b0, !(exp_valid || exp_idle)});
    check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
    check("inst",       inst,    exp_inst);
    check("inst_pc",    inst_pc, exp_pc);
    if (mem_busy) begin
      check("imem_addr_hold", imem_addr, mem_addr);
    end else if (imem_req === 1'b1) begin
      check("req_addr", imem_addr, exp_addr);
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = int'($urandom_range(1, lat_max));
      started  = 1'b1;
    end

    ack_now = 1'b0;
    if (!do_rst && mem_busy && !started) begin
      mem_cnt--;
      if (mem_cnt == 0) ack_now = 1'b1;
    end
    pw  = force_pcwr || (int'($urandom_range(0, 99)) < pcwr_pct);
    tgt = force_pcwr ? force_tgt : pick_target();
    rdy = int'($urandom_range(0, 99)) < ready_pct;

    rst        = do_rst;
    PCWr       = pw;
    target     = tgt;
    inst_ready = rdy;
    imem_ack   = ack_now;
    imem_rdata = ack_now ? mem_word(mem_addr) : $urandom();

    if (do_rst) begin
      exp_valid    = 1'b0;
      exp_idle     = 1'b1;
      exp_addr     = {RST_PC[31:2], 2'b00};
      exp_inst     = '0;
      exp_pc       = '0;
      mem_busy     = 1'b0;
      redirected   = 1'b0;
      wrap_pending = 1'b0;
    end else begin
      deliver = ack_now && !redirected && !pw;
      accept  = exp_valid && rdy && !pw;
      nv      = deliver || (exp_valid && !rdy && !pw);
      if (accept) begin
        exp_addr     = exp_pc + 32'd4;
        wrap_pending = (exp_pc == 32'hFFFF_FFFC);
      end
      if (pw) begin
        exp_addr     = {tgt[31:2], 2'b00};
        wrap_pending = 1'b0;
        if (mem_busy && !ack_now) redirected = 1'b1;
      end
      if (deliver) begin
        exp_inst = mem_word(mem_addr);
        exp_pc   = mem_addr;
        if (wrap_pending && mem_addr == 32'h0) saw_wrap = 1'b1;
      end
      if (ack_now) begin
        mem_busy   = 1'b0;
        redirected = 1'b0;
      end
      exp_valid = nv;
      exp_idle  = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      tick(1'b0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; PCWr = 1'b0; target = '0; inst_ready = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    exp_valid = 1'b0; exp_idle = 1'b1; exp_addr = RST_PC; exp_inst = '0; exp_pc = '0;
    mem_busy = 1'b0; redirected = 1'b0; wrap_pending = 1'b0; saw_wrap = 1'b0;
    mem_cnt = 0; mem_addr = '0;
    pcwr_pct = 0; ready_pct = 100; lat_max = 1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 32'h0000_0300);
      @(negedge CLK);
    end
    tick(1'b0, 1'b0, 32'h0);

    // straight-line, single-cycle memory, decode always ready
    run(20);
    // backpressure
    ready_pct = 30; lat_max = 2;
    run(40);

    // redirect to 0x100 while a request is outstanding
    ready_pct = 100; lat_max = 3; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (mem_busy && mem_cnt > 1) begin found = 1'b1; tick(1'b0, 1'b1, 32'h0000_0100); end
      else tick(1'b0, 1'b0, 32'h0);
    end
    check("wait_outstanding", {31'b0, found}, 32'd1);
    run(15);

    // redirect to 0x200 in the same cycle as the ack
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (mem_busy && mem_cnt == 1) begin found = 1'b1; tick(1'b0, 1'b1, 32'h0000_0200); end
      else tick(1'b0, 1'b0, 32'h0);
    end
    check("wait_ack_cycle", {31'b0, found}, 32'd1);
    run(15);

    // redirect to 0x40 while valid and ready together
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (exp_valid) begin found = 1'b1; tick(1'b0, 1'b1, 32'h0000_0040); end
      else tick(1'b0, 1'b0, 32'h0);
    end
    check("wait_valid", {31'b0, found}, 32'd1);
    run(15);

    // wrap from the top of the address space
    @(negedge CLK);
    tick(1'b0, 1'b1, 32'hFFFF_FFFF);
    run(20);
    check("wrap_seen", {31'b0, saw_wrap}, 32'd1);

    // reset in the middle of a request, with a redirect in the same cycle
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (mem_busy) begin found = 1'b1; tick(1'b1, 1'b1, 32'h0000_0500); end
      else tick(1'b0, 1'b0, 32'h0);
    end
    check("wait_fetch_for_reset", {31'b0, found}, 32'd1);
    run(10);

    // mixed random traffic with occasional resets
    pcwr_pct = 15; ready_pct = 60; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      tick($urandom_range(0, 199) == 0, 1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
